// File: rtl/dmem_access_ctrl_if.sv
// Core-side request/response bundle of the data-memory access controller.
// The core is the master; the controller is the slave.
interface dmem_access_ctrl_if #(
    parameter int DATA_BIT_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_wr;
    logic [DATA_BIT_WIDTH-1:0] req_addr;
    logic [DATA_BIT_WIDTH-1:0] req_wdata;
    logic                      resp_valid;
    logic [DATA_BIT_WIDTH-1:0] resp_rdata;
    logic                      resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Single-outstanding load/store controller for the data memory: checks alignment and range,
// sequences address/data ahead of the memory's negedge write, and returns a one-cycle response.
module dmem_access_ctrl #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int DMEMADDRBITS   = 13,
    parameter int DMEMWORDBITS   = 2,
    parameter int WAIT_CYCLES    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    dmem_access_ctrl_if.slave         bus,
    output logic [DATA_BIT_WIDTH-1:0] mem_addr,
    output logic [DATA_BIT_WIDTH-1:0] mem_dataIn,
    output logic                      mem_isWrRegMem,
    input  logic [DATA_BIT_WIDTH-1:0] mem_regOut
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       wr_q;
    logic       fault;

    // Misaligned word, or address bits above what the memory decodes.
    assign fault = (|bus.req_addr[DMEMWORDBITS-1:0]) ||
                   (|bus.req_addr[DATA_BIT_WIDTH-1:DMEMADDRBITS]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            wr_q           <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            mem_addr       <= '0;
            mem_dataIn     <= '0;
            mem_isWrRegMem <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each is high for exactly the one
            // cycle of the state that sets it; all state uses non-blocking assignment.
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            mem_isWrRegMem <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        wr_q          <= bus.req_wr;
                        bus.req_ready <= 1'b0;
                        if (fault) begin
                            state          <= ST_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else begin
                            mem_addr   <= bus.req_addr;
                            mem_dataIn <= bus.req_wdata;
                            state      <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    // Memory captures address/data at the end of ISSUE; write on the
                    // following negedge, inside the first WAIT cycle.
                    wait_cnt       <= 4'(WAIT_CYCLES);
                    mem_isWrRegMem <= wr_q;
                    state          <= ST_WAIT;
                end

                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state          <= ST_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= wr_q ? '0 : mem_regOut;
                    end
                end

                ST_RESP: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                end

                default: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side load/store controller for the data memory.
- Accepts single word load/store requests from the core over a valid/ready handshake.
- Drives the data memory's address, write-data and write-enable inputs, sequencing around the memory's registered address/data capture and its negedge write.
- Returns load data, or a fault flag, on a one-cycle response strobe.
- Sits between the core's memory stage and the data memory, one outstanding request at a time.

Parameters:
- DATA_BIT_WIDTH, 32, width of addresses and data words.
- DMEMADDRBITS, 13, number of byte-address bits decoded by the data memory.
- DMEMWORDBITS, 2, log2 of bytes per word; these low address bits must be zero.
- WAIT_CYCLES, 1, cycles between address issue and valid memory read data; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  core request present
- req_ready  output  1  controller can accept a request this cycle
- req_wr  input  1  1 = store, 0 = load
- req_addr  input  DATA_BIT_WIDTH  byte address
- req_wdata  input  DATA_BIT_WIDTH  store data
- resp_valid  output  1  one-cycle response strobe
- resp_rdata  output  DATA_BIT_WIDTH  load data; 0 for stores and faults
- resp_err  output  1  request faulted (misaligned or out of range), qualified by resp_valid
- mem_addr  output  DATA_BIT_WIDTH  address to data memory
- mem_dataIn  output  DATA_BIT_WIDTH  write data to data memory
- mem_isWrRegMem  output  1  data memory write enable
- mem_regOut  input  DATA_BIT_WIDTH  data memory read data

Behaviour:
- Reset is synchronous, active-high, clock clk.
  - On reset: state IDLE, wait counter 0, all latches 0.
  - Reset outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_dataIn=0, mem_isWrRegMem=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Handshake:
  - req_ready=1 only in IDLE.
  - A transfer occurs on a rising edge with req_valid & req_ready.
  - req_valid is ignored in all other states; no queuing.
- IDLE, on transfer:
  - Latch req_wr, req_addr, req_wdata.
  - Fault if req_addr[DMEMWORDBITS-1:0] != 0, or any bit of req_addr[DATA_BIT_WIDTH-1:DMEMADDRBITS] is set.
  - Fault: go to RESP with err latched; memory is never accessed; mem_isWrRegMem stays 0.
  - Otherwise: go to ISSUE.
- ISSUE, one cycle:
  - mem_addr and mem_dataIn drive the latched values. They hold through WAIT and RESP and change only on the next accepted request.
  - mem_isWrRegMem=0.
  - Wait counter loads WAIT_CYCLES. Next state WAIT.
- WAIT:
  - Counter decrements each cycle; exit to RESP on the edge where the counter equals 1.
  - Stores: mem_isWrRegMem=1 during the first WAIT cycle only, so the memory's negedge write occurs exactly once, after its posedge address/data capture.
  - Loads: mem_isWrRegMem=0; resp_rdata captures mem_regOut on the exit edge.
- RESP, one cycle:
  - resp_valid=1; resp_err as latched.
  - resp_rdata = captured load data, else 0.
  - Next state IDLE.
  - resp_rdata and resp_err return to 0 when leaving RESP.
- Latency:
  - Accept edge E0: ISSUE after E0, WAIT after E1, RESP after E(1+WAIT_CYCLES), IDLE after E(2+WAIT_CYCLES).
  - Faulted request: RESP after E0, IDLE after E1.
  - Back-to-back throughput: one request per (3+WAIT_CYCLES) cycles.
- Reset mid-operation:
  - Any state returns to IDLE at the next edge; no response is produced.
  - A store whose first WAIT cycle has begun when reset is sampled is committed, because the negedge within that cycle has already written. Any earlier store is not written.
- Width rules: counter width 4 bits; mem_addr is passed full width, and the memory slices its own word index.

Test Plan:
- Store then load: store addr 0x0000_0010, data 0xDEAD_BEEF; then load 0x10 -> mem_isWrRegMem high exactly one cycle; load resp_valid 3 cycles after accept, resp_rdata=0xDEAD_BEEF, resp_err=0.
- Misaligned load addr 0x0000_0006 -> resp_valid the cycle after accept, resp_err=1, resp_rdata=0, mem_isWrRegMem never asserted, mem_addr unchanged.
- Out-of-range store addr 0x0000_2000 (DMEMADDRBITS=13) -> resp_err=1, no memory write; a subsequent load of 0x0 returns its prior value.
- req_valid held high with alternating store/load to 0x4, 0x8 -> req_ready low outside IDLE, exactly one accept per 4 cycles, responses in order with correct data, no dropped or duplicated writes.
- WAIT_CYCLES=3 with memory read data delayed 3 cycles -> load resp_valid 5 cycles after accept with the correct word; store write strobe still exactly one cycle.
- Reset asserted in ISSUE of a store to 0xC (data 0x1234_5678) -> no resp_valid, all outputs at reset values next cycle, memory[0xC] unchanged. Repeat with reset in the first WAIT cycle -> memory[0xC]=0x1234_5678, no response.
